keyboard_entry_ctrl: RTL and testbench

// - Sequences PS/2 keyboard events into a 4-digit decimal entry buffer and drives the
//   4-digit multiplexed seven-segment display. Sits between KeyboardDecoder (key_valid,

---
 rtl/keyboard_entry_ctrl.sv | 148 ++++++++++++++
 tb/tb_keyboard_entry_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_entry_ctrl.sv
// Keyboard entry controller: turns PS/2 key events into a 4-digit BCD entry
// buffer with backspace/clear/commit, and scans it onto a 4-digit display.
module keyboard_entry_ctrl #(
  parameter int unsigned SCAN_BITS  = 17,
  parameter logic [3:0]  BLANK_CODE = 4'hF,
  parameter bit          USE_KEYPAD = 1'b1
) (
  input  logic         fcrystal,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic [3:0]   code,
  output logic [3:0]   ssd_ctl,
  output logic [15:0]  entry_value,
  output logic [2:0]   entry_count,
  output logic [15:0]  commit_value,
  output logic         commit_valid,
  output logic         overflow
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COUNT_W = 3;
  localparam int unsigned DIGITS  = 4;

  typedef enum logic {IDLE, HELD} state_t;

  state_t               state;
  logic [8:0]           held_code;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [1:0]           scan_pos;

  logic               kd_digit;
  logic [DIGIT_W-1:0] kd_val;
  logic               kd_enter;
  logic               kd_bs;
  logic               kd_esc;
  logic               press;
  logic               recognised;

  // Map the current scan code onto an action class (and digit value).
  always_comb begin
    kd_digit = 1'b0;
    kd_val   = '0;
    kd_enter = 1'b0;
    kd_bs    = 1'b0;
    kd_esc   = 1'b0;
    case (last_change)
      9'h045: begin kd_digit = 1'b1; kd_val = 4'd0; end
      9'h016: begin kd_digit = 1'b1; kd_val = 4'd1; end
      9'h01E: begin kd_digit = 1'b1; kd_val = 4'd2; end
      9'h026: begin kd_digit = 1'b1; kd_val = 4'd3; end
      9'h025: begin kd_digit = 1'b1; kd_val = 4'd4; end
      9'h02E: begin kd_digit = 1'b1; kd_val = 4'd5; end
      9'h036: begin kd_digit = 1'b1; kd_val = 4'd6; end
      9'h03D: begin kd_digit = 1'b1; kd_val = 4'd7; end
      9'h03E: begin kd_digit = 1'b1; kd_val = 4'd8; end
      9'h046: begin kd_digit = 1'b1; kd_val = 4'd9; end
      9'h05A: kd_enter = 1'b1;
      9'h066: kd_bs    = 1'b1;
      9'h076: kd_esc   = 1'b1;
      default: ;
    endcase
    if (USE_KEYPAD) begin
      case (last_change)
        9'h070: begin kd_digit = 1'b1; kd_val = 4'd0; end
        9'h069: begin kd_digit = 1'b1; kd_val = 4'd1; end
        9'h072: begin kd_digit = 1'b1; kd_val = 4'd2; end
        9'h07A: begin kd_digit = 1'b1; kd_val = 4'd3; end
        9'h06B: begin kd_digit = 1'b1; kd_val = 4'd4; end
        9'h073: begin kd_digit = 1'b1; kd_val = 4'd5; end
        9'h074: begin kd_digit = 1'b1; kd_val = 4'd6; end
        9'h06C: begin kd_digit = 1'b1; kd_val = 4'd7; end
        9'h075: begin kd_digit = 1'b1; kd_val = 4'd8; end
        9'h07D: begin kd_digit = 1'b1; kd_val = 4'd9; end
        9'h15A: kd_enter = 1'b1;
        default: ;
      endcase
    end
  end

  assign press      = key_valid && key_down[last_change];
  assign recognised = kd_digit || kd_enter || kd_bs || kd_esc;

  // Entry FSM: one action per physical press, then wait in HELD for release.
  always_ff @(posedge fcrystal or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      held_code    <= '0;
      scan_cnt     <= '0;
      entry_value  <= '0;
      entry_count  <= '0;
      commit_value <= '0;
      commit_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      scan_cnt     <= scan_cnt + SCAN_BITS'(1);
      commit_valid <= 1'b0;
      overflow     <= 1'b0;
      case (state)
        IDLE: begin
          if (press && recognised) begin
            held_code <= last_change;
            state     <= HELD;
            if (kd_digit) begin
              if (entry_count < COUNT_W'(DIGITS)) begin
                entry_value <= {entry_value[11:0], kd_val};
                entry_count <= entry_count + COUNT_W'(1);
              end else begin
                overflow <= 1'b1;
              end
            end else if (kd_bs) begin
              if (entry_count != '0) begin
                entry_value <= {4'h0, entry_value[15:4]};
                entry_count <= entry_count - COUNT_W'(1);
              end
            end else if (kd_esc) begin
              entry_value <= '0;
              entry_count <= '0;
            end else if (kd_enter) begin
              if (entry_count != '0) begin
                commit_value <= entry_value;
                commit_valid <= 1'b1;
                entry_value  <= '0;
                entry_count  <= '0;
              end
            end
          end
        end
        HELD: begin
          if (!key_down[held_code]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display decode: right-justified digits, unoccupied positions blanked.
  always_comb begin
    scan_pos = scan_cnt[SCAN_BITS-1 -: 2];
    ssd_ctl  = ~(4'b0001 << scan_pos);
    if (COUNT_W'(scan_pos) < entry_count)
      code = entry_value[{scan_pos, 2'b00} +: DIGIT_W];
    else
      code = BLANK_CODE;
  end

endmodule

// File: tb/tb_keyboard_entry_ctrl.sv
// Bench for keyboard_entry_ctrl: commits are scoreboarded through a queue,
// buffer state and display are checked against values derived from the key sequence.
module tb_keyboard_entry_ctrl;

  logic         fcrystal = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic [3:0]   code;
  logic [3:0]   ssd_ctl;
  logic [15:0]  entry_value;
  logic [2:0]   entry_count;
  logic [15:0]  commit_value;
  logic         commit_valid;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;
  int ovf_cnt = 0;
  int commit_cnt = 0;
  logic [15:0] commit_q [$];

  logic [8:0] row_code [10];
  logic [3:0] exp_code [4];

  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_KP_ENTER = 9'h15A;
  localparam logic [8:0] K_BS    = 9'h066;
  localparam logic [8:0] K_ESC   = 9'h076;

  keyboard_entry_ctrl #(.SCAN_BITS(4), .BLANK_CODE(4'hF), .USE_KEYPAD(1'b1)) dut (
    .fcrystal    (fcrystal),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .code        (code),
    .ssd_ctl     (ssd_ctl),
    .entry_value (entry_value),
    .entry_count (entry_count),
    .commit_value(commit_value),
    .commit_valid(commit_valid),
    .overflow    (overflow)
  );

  always #5 fcrystal = ~fcrystal;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse key_valid for a make event; the key stays down afterwards.
  task automatic key_press(input logic [8:0] kc);
    @(negedge fcrystal);
    last_change  = kc;
    key_down[kc] = 1'b1;
    key_valid    = 1'b1;
    @(negedge fcrystal);
    key_valid    = 1'b0;
  endtask

  // Repeated make pulse for a key already held (typematic).
  task automatic key_repeat(input logic [8:0] kc);
    @(negedge fcrystal);
    last_change = kc;
    key_valid   = 1'b1;
    @(negedge fcrystal);
    key_valid   = 1'b0;
  endtask

  task automatic key_release(input logic [8:0] kc);
    @(negedge fcrystal);
    last_change  = kc;
    key_down[kc] = 1'b0;
    key_valid    = 1'b1;
    @(negedge fcrystal);
    key_valid    = 1'b0;
  endtask

  task automatic tap(input logic [8:0] kc);
    key_press(kc);
    key_release(kc);
  endtask

  // Commit/overflow monitor: commits are popped from the scoreboard.
  always @(negedge fcrystal) begin
    if (rst_n === 1'b1) begin
      if (overflow) ovf_cnt++;
      if (commit_valid) begin
        commit_cnt++;
        check_eq("commit_expected", 32'(commit_q.size() != 0), 32'd1);
        if (commit_q.size() != 0) check_eq("commit_value", 32'(commit_value), 32'(commit_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_base;
    int commit_base;
    row_code = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
    exp_code = '{4'h3, 4'h2, 4'h1, 4'hF};
    rst_n       = 1'b0;
    key_valid   = 1'b0;
    last_change = '0;
    key_down    = '0;
    repeat (3) @(negedge fcrystal);

    check_eq("rst_entry_value", 32'(entry_value), 32'h0);
    check_eq("rst_entry_count", 32'(entry_count), 32'd0);
    check_eq("rst_commit_value", 32'(commit_value), 32'h0);
    check_eq("rst_commit_valid", 32'(commit_valid), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_ssd_ctl", 32'(ssd_ctl), 32'hE);
    check_eq("rst_code", 32'(code), 32'hF);
    rst_n = 1'b1;

    // Digits 1,2,3 then scan every position.
    tap(row_code[1]); tap(row_code[2]); tap(row_code[3]);
    check_eq("e123_value", 32'(entry_value), 32'h0123);
    check_eq("e123_count", 32'(entry_count), 32'd3);
    for (int p = 0; p < 4; p++) begin
      automatic int t = 0;
      automatic logic [3:0] want = ~(4'b0001 << p);
      while (ssd_ctl !== want && t < 64) begin
        @(negedge fcrystal);
        t++;
      end
      check_eq("scan_pos_reached", 32'(t < 64), 32'd1);
      check_eq("scan_code", 32'(code), 32'(exp_code[p]));
    end

    // Fill to four digits, fifth is rejected with a single overflow pulse.
    tap(K_ESC);
    ovf_base = ovf_cnt;
    for (int d = 1; d <= 4; d++) tap(row_code[d]);
    check_eq("ovf_none_before_full", 32'(ovf_cnt - ovf_base), 32'd0);
    tap(row_code[5]);
    repeat (3) @(negedge fcrystal);
    check_eq("full_value", 32'(entry_value), 32'h1234);
    check_eq("full_count", 32'(entry_count), 32'd4);
    check_eq("ovf_one_cycle", 32'(ovf_cnt - ovf_base), 32'd1);

    // Backspace, clear, backspace on empty.
    tap(K_BS);
    check_eq("bs_value", 32'(entry_value), 32'h0123);
    check_eq("bs_count", 32'(entry_count), 32'd3);
    tap(K_ESC);
    check_eq("esc_value", 32'(entry_value), 32'h0);
    check_eq("esc_count", 32'(entry_count), 32'd0);
    tap(K_BS);
    check_eq("bs_empty_value", 32'(entry_value), 32'h0);
    check_eq("bs_empty_count", 32'(entry_count), 32'd0);

    // Commit 98, then Enter on an empty buffer must not pulse.
    tap(row_code[9]); tap(row_code[8]);
    commit_base = commit_cnt;
    commit_q.push_back(16'h0098);
    tap(K_ENTER);
    check_eq("commit_reg", 32'(commit_value), 32'h0098);
    check_eq("commit_clears_entry", 32'(entry_value), 32'h0);
    check_eq("commit_clears_count", 32'(entry_count), 32'd0);
    tap(K_ENTER);
    repeat (2) @(negedge fcrystal);
    check_eq("commit_pulses", 32'(commit_cnt - commit_base), 32'd1);

    // Keypad digits and keypad Enter.
    tap(9'h069); tap(9'h07D);
    check_eq("keypad_value", 32'(entry_value), 32'h0019);
    commit_q.push_back(16'h0019);
    tap(K_KP_ENTER);
    check_eq("kp_enter_commit", 32'(commit_value), 32'h0019);

    // Typematic repeats and a chord while 7 is held.
    key_press(row_code[7]);
    key_repeat(row_code[7]);
    key_repeat(row_code[7]);
    key_repeat(row_code[7]);
    key_press(row_code[5]);
    key_release(row_code[5]);
    check_eq("held_value", 32'(entry_value), 32'h0007);
    key_release(row_code[7]);
    check_eq("hold_value", 32'(entry_value), 32'h0007);
    check_eq("hold_count", 32'(entry_count), 32'd1);

    // Asynchronous reset mid-operation with a key still held.
    tap(K_ESC);
    tap(row_code[4]); tap(row_code[2]);
    key_press(row_code[4]);
    check_eq("pre_rst_value", 32'(entry_value), 32'h0424);
    repeat (5) @(negedge fcrystal);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_entry_value", 32'(entry_value), 32'h0);
    check_eq("arst_entry_count", 32'(entry_count), 32'd0);
    check_eq("arst_commit_value", 32'(commit_value), 32'h0);
    check_eq("arst_ssd_ctl", 32'(ssd_ctl), 32'hE);
    check_eq("arst_code", 32'(code), 32'hF);
    @(negedge fcrystal);
    rst_n = 1'b1;
    key_repeat(row_code[4]);
    check_eq("post_rst_press_value", 32'(entry_value), 32'h0004);
    check_eq("post_rst_press_count", 32'(entry_count), 32'd1);
    key_release(row_code[4]);

    repeat (2) @(negedge fcrystal);
    check_eq("commit_q_drained", 32'(commit_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
